// File: rtl/cpu_exec_controller.sv
// Multi-cycle fetch/execute controller for the 8-bit CPU.
// It fetches 16-bit instructions, drives the external ALU, and commits the results to a 4x8 register file.
module cpu_exec_controller #(
  parameter logic [7:0] RESET_PC      = 8'h00,
  parameter bit         HALT_ON_UNDEF = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [7:0]  alu_operand1,
  output logic [7:0]  alu_operand2,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        flag_z,
  output logic        flag_v,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [3:0] OP_BRZ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_UND0 = 4'hD;
  localparam logic [3:0] OP_UND1 = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];
  logic        flag_z_q, flag_z_d;
  logic        flag_v_q, flag_v_d;
  logic        imem_req_q, imem_req_d;
  logic        halted_q, halted_d;

  logic [3:0]  opcode;
  logic [1:0]  rd, rs, rt;
  logic [7:0]  imm8;
  logic        is_alu, is_undef, go_halt;

  assign opcode   = ir_q[15:12];
  assign rd       = ir_q[11:10];
  assign rs       = ir_q[9:8];
  assign rt       = ir_q[7:6];
  assign imm8     = ir_q[7:0];
  assign is_alu   = (opcode <= 4'd9);
  assign is_undef = (opcode == OP_UND0) || (opcode == OP_UND1);
  assign go_halt  = (opcode == OP_HALT) || (is_undef && HALT_ON_UNDEF);

  // The ALU is only driven during EXEC of an ALU op; otherwise it sees the idle code.
  always_comb begin
    alu_op       = 4'hF;
    alu_operand1 = 8'h00;
    alu_operand2 = 8'h00;
    if (state_q == EXEC && is_alu) begin
      alu_op       = opcode;
      alu_operand1 = regs_q[rs];
      alu_operand2 = opcode[0] ? imm8 : regs_q[rt];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    regs_d   = regs_q;
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_alu) begin
          regs_d[rd] = alu_result;
          flag_z_d   = alu_zero;
          flag_v_d   = alu_ovf;
        end
        // A taken branch overrides the increment already applied during fetch.
        if ((opcode == OP_BRZ && flag_z_q) || opcode == OP_JMP) pc_d = imm8;
        state_d = go_halt ? HALT : FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    imem_req_d = (state_d == FETCH);
    halted_d   = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      regs_q     <= '{default: 8'h00};
      flag_z_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      imem_req_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      regs_q     <= regs_d;
      flag_z_q   <= flag_z_d;
      flag_v_q   <= flag_v_d;
      imem_req_q <= imem_req_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign flag_z    = flag_z_q;
  assign flag_v    = flag_v_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_exec_controller.sv
// Scoreboard bench for cpu_exec_controller: an instruction-level ISA model predicts ALU drive and fetch behaviour.
// A separate monitor checks each EXEC cycle and each new fetch against those predictions.
module tb_cpu_exec_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [7:0]  alu_operand1, alu_operand2;
  logic [3:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_zero, alu_ovf;
  logic        flag_z, flag_v, halted;

  int n_compared = 0;
  int n_mismatched = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  cpu_exec_controller dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .flag_z(flag_z), .flag_v(flag_v), .halted(halted)
  );

  // Returns {ovf, zero, result} with overflow taken from true signed arithmetic.
  function automatic logic [9:0] alu_calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, full;
    logic [7:0] r;
    logic v;
    sa = $signed(a);
    sb = $signed(b);
    v = 1'b0;
    r = 8'h00;
    case (op[3:1])
      3'd0: begin full = sa + sb; r = a + b; v = (full > 127) || (full < -128); end
      3'd1: begin full = sa - sb; r = a - b; v = (full > 127) || (full < -128); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = 8'h00;
    endcase
    return {v, (r == 8'h00), r};
  endfunction

  assign {alu_ovf, alu_zero, alu_result} = alu_calc(alu_op, alu_operand1, alu_operand2);

  typedef struct packed {logic [3:0] op; logic [7:0] a; logic [7:0] b;} exec_t;
  typedef struct packed {logic [7:0] addr; logic z; logic v;} fetch_t;

  exec_t       exec_q[$];
  fetch_t      fetch_q[$];
  int          wait_q[$];
  logic [15:0] prog_q[$];
  int          rand_count = 0;

  logic [7:0] m_pc;
  logic [7:0] m_regs [4];
  logic       m_z, m_v;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 8'h00;
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_z = 1'b0;
    m_v = 1'b0;
    exec_q.delete();
    fetch_q.delete();
    wait_q.delete();
    fetch_q.push_back('{addr: 8'h00, z: 1'b0, v: 1'b0});
  endfunction

  // Architectural effect of one instruction, decided when it is handed to the DUT.
  function automatic void model_exec(input logic [15:0] w);
    logic [3:0] op;
    logic [7:0] a, b, imm;
    logic [9:0] res;
    op  = w[15:12];
    imm = w[7:0];
    m_pc = m_pc + 8'd1;
    if (op <= 4'd9) begin
      a = m_regs[w[9:8]];
      b = op[0] ? imm : m_regs[w[7:6]];
      res = alu_calc(op, a, b);
      exec_q.push_back('{op: op, a: a, b: b});
      m_regs[w[11:10]] = res[7:0];
      m_z = res[8];
      m_v = res[9];
    end else begin
      exec_q.push_back('{op: 4'hF, a: 8'h00, b: 8'h00});
      if ((op == 4'hB && m_z) || op == 4'hC) m_pc = imm;
    end
    if (op != 4'hF) fetch_q.push_back('{addr: m_pc, z: m_z, v: m_v});
  endfunction

  function automatic logic [15:0] gen_instr();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 19);
    if (r < 14) op = 4'($urandom_range(0, 9));
    else begin
      case (r)
        14: op = 4'hA;
        15, 19: op = 4'hB;
        16: op = 4'hC;
        17: op = 4'hD;
        default: op = 4'hE;
      endcase
    end
    return {op, 12'($urandom)};
  endfunction

  function automatic logic [15:0] next_instr();
    if (prog_q.size() > 0) return prog_q.pop_front();
    if (rand_count > 0) begin
      rand_count--;
      return gen_instr();
    end
    return 16'hF000;
  endfunction

  // Memory responder: directed instructions are acked with zero wait, random ones after 0-3 wait cycles.
  int wait_left = -1;
  int cur_wait = 0;
  always @(negedge clk) begin
    logic [15:0] w;
    imem_ack = 1'b0;
    if (!rst_n) wait_left = -1;
    else if (imem_req) begin
      if (wait_left < 0) begin
        wait_left = (prog_q.size() > 0) ? 0 : $urandom_range(0, 3);
        cur_wait = wait_left;
      end
      if (wait_left == 0) begin
        w = next_instr();
        imem_data = w;
        imem_ack = 1'b1;
        wait_q.push_back(cur_wait);
        model_exec(w);
        wait_left = -1;
      end else begin
        wait_left--;
        imem_data = 16'($urandom);
      end
    end else if ($urandom_range(0, 1) == 0) begin
      imem_ack = 1'b1;
      imem_data = 16'($urandom);
    end
  end

  logic ack_taken;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_taken <= 1'b0;
    else ack_taken <= imem_req && imem_ack;
  end

  // Monitor: the cycle after an accepted ack is EXEC; a rising imem_req is a new fetch.
  bit req_prev = 1'b0;
  bit have_last = 1'b0;
  int last_rise = 0;
  logic [7:0] cur_addr = 8'h00;
  always @(negedge clk) begin
    exec_t e;
    fetch_t f;
    if (!rst_n) begin
      req_prev = 1'b0;
      have_last = 1'b0;
    end else begin
      if (ack_taken) begin
        if (exec_q.size() == 0) checkOutput("exec_unexpected", 1, 0);
        else begin
          e = exec_q.pop_front();
          checkOutput("exec_alu_op", alu_op, e.op);
          checkOutput("exec_operand1", alu_operand1, e.a);
          checkOutput("exec_operand2", alu_operand2, e.b);
        end
      end else begin
        checkOutput("idle_alu_drive", {alu_op, alu_operand1, alu_operand2}, {4'hF, 16'h0000});
      end
      if (imem_req && !req_prev) begin
        if (fetch_q.size() == 0) checkOutput("fetch_unexpected", 1, 0);
        else begin
          f = fetch_q.pop_front();
          checkOutput("fetch_addr", imem_addr, f.addr);
          checkOutput("fetch_flags", {flag_z, flag_v}, {f.z, f.v});
          cur_addr = f.addr;
        end
        if (have_last) begin
          if (wait_q.size() == 0) checkOutput("wait_record", 1, 0);
          else checkOutput("fetch_interval", cycle - last_rise, 2 + wait_q.pop_front());
        end
        have_last = 1'b1;
        last_rise = cycle;
      end else if (imem_req) begin
        checkOutput("stall_addr_stable", imem_addr, cur_addr);
      end
      req_prev = imem_req;
    end
  end

  task automatic applyStimulus(input logic [15:0] prog[], input int n_rand);
    foreach (prog[i]) prog_q.push_back(prog[i]);
    rand_count = n_rand;
  endtask

  task automatic applyReset(input int n);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      checkOutput("reset_req", imem_req, 0);
      checkOutput("reset_halted", halted, 0);
      checkOutput("reset_flags", {flag_z, flag_v}, 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_cycle_req", imem_req, 0);
  endtask

  task automatic waitHalt(input string name, input int budget);
    int i;
    for (i = 0; i < budget && !halted; i++) @(negedge clk);
    checkOutput(name, halted, 1);
  endtask

  initial begin
    model_reset();
    // Overflow, zero+taken branch, not-taken branch, jump to 0xFF with wrap, undefined-as-NOP.
    applyStimulus('{16'h147F, 16'h1501, 16'h2940, 16'hB020, 16'h1C01, 16'hB040,
                    16'hC0FF, 16'hA000, 16'hD123, 16'hE000}, 200);
    applyReset(3);
    waitHalt("halt_reached", 20000);
    repeat (10) begin
      @(negedge clk);
      checkOutput("halt_held", halted, 1);
      checkOutput("halt_no_req", imem_req, 0);
    end

    // Reset landing in the EXEC cycle of an ADDI must discard its write.
    applyStimulus('{16'h1455, 16'h0940}, 0);
    applyReset(2);
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        @(posedge clk);
        #1;
        if (ack_taken) break;
      end
      checkOutput("midexec_reached", ack_taken, 1);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("midexec_reset_req", imem_req, 0);
    checkOutput("midexec_reset_addr", imem_addr, 8'h00);
    checkOutput("midexec_reset_alu", alu_op, 4'hF);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    waitHalt("halt_after_midexec", 100);
    checkOutput("scoreboard_drained", exec_q.size() + fetch_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
